// File: rtl/prf_pkg.sv
// Shared constants and helpers for the multiported physical register file.
package prf_pkg;

    localparam int unsigned PRF_SIZE_DEF  = 16;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned ARCH_REGS_DEF = 8;
    localparam int unsigned WB_PORTS_DEF  = 2;
    localparam int unsigned RD_PORTS_DEF  = 2;

    // Widest register file the priority encoder supports.
    localparam int unsigned MAX_REGS = 64;
    localparam int unsigned MAX_ID_W = 6;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } lowest_t;

    function automatic lowest_t lowest_set(input logic [MAX_REGS-1:0] vec);
        lowest_t res;
        res = '0;
        for (int i = MAX_REGS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = MAX_ID_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prf_free_list.sv
// Free bitmap with lowest-index allocation and retire-time release.
module prf_free_list
    import prf_pkg::*;
#(
    parameter int unsigned PRF_SIZE  = PRF_SIZE_DEF,
    parameter int unsigned ARCH_REGS = ARCH_REGS_DEF,
    parameter int unsigned ID_W      = $clog2(PRF_SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    output logic            alloc_grant,
    output logic [ID_W-1:0] alloc_id,
    output logic [ID_W:0]   free_count,
    input  logic            rel_ena,
    input  logic [ID_W-1:0] rel_id
);

    logic [PRF_SIZE-1:0] free_q, free_d;
    logic [ID_W:0]       count_q, count_d;
    lowest_t             low;
    logic                rel_ok;

    always_comb begin
        low         = lowest_set(MAX_REGS'(free_q));
        alloc_grant = alloc_req && low.found;
        alloc_id    = low.found ? ID_W'(low.idx) : '0;
        // Releasing reg 0 or an already-free reg must not touch the count.
        rel_ok      = rel_ena && (rel_id != '0) && !free_q[rel_id];

        free_d = free_q;
        if (alloc_grant) free_d[alloc_id] = 1'b0;
        if (rel_ok)      free_d[rel_id]   = 1'b1;
        count_d = count_q + (ID_W+1)'(rel_ok) - (ID_W+1)'(alloc_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                free_q[i] <= (i >= ARCH_REGS) && (i != 0);
            end
            count_q <= (ID_W+1)'(PRF_SIZE - ARCH_REGS);
        end else begin
            free_q  <= free_d;
            count_q <= count_d;
        end
    end

    assign free_count = count_q;

endmodule

// File: rtl/prf_multiport.sv
// Physical register file: writeback ports, CDB read ports with write-first bypass, free list.
module prf_multiport
    import prf_pkg::*;
#(
    parameter int unsigned PRF_SIZE  = PRF_SIZE_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ARCH_REGS = ARCH_REGS_DEF,
    parameter int unsigned WB_PORTS  = WB_PORTS_DEF,
    parameter int unsigned RD_PORTS  = RD_PORTS_DEF,
    parameter int unsigned ID_W      = $clog2(PRF_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WB_PORTS-1:0]        wb_ena,
    input  logic [WB_PORTS*ID_W-1:0]   wb_id,
    input  logic [WB_PORTS*DATA_W-1:0] wb_val,
    input  logic                       alloc_req,
    output logic                       alloc_grant,
    output logic [ID_W-1:0]            alloc_id,
    output logic [ID_W:0]              free_count,
    input  logic                       rel_ena,
    input  logic [ID_W-1:0]            old_wb,
    input  logic [RD_PORTS-1:0]        requesting,
    input  logic [RD_PORTS*ID_W-1:0]   requested_id,
    output logic [PRF_SIZE-1:0]        ready_regs,
    output logic [RD_PORTS-1:0]        cdb_transmit,
    output logic [RD_PORTS*ID_W-1:0]   cdb_id,
    output logic [RD_PORTS*DATA_W-1:0] cdb_val
);

    logic [DATA_W-1:0]          data_q [PRF_SIZE];
    logic [DATA_W-1:0]          data_d [PRF_SIZE];
    logic [PRF_SIZE-1:0]        ready_q, ready_d;
    logic [RD_PORTS-1:0]        tx_q, tx_d;
    logic [RD_PORTS*ID_W-1:0]   cid_q, cid_d;
    logic [RD_PORTS*DATA_W-1:0] cval_q, cval_d;
    logic [ID_W-1:0]            rid, wid;
    logic                       hit;
    logic [DATA_W-1:0]          bval;

    prf_free_list #(
        .PRF_SIZE  (PRF_SIZE),
        .ARCH_REGS (ARCH_REGS),
        .ID_W      (ID_W)
    ) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_grant (alloc_grant),
        .alloc_id    (alloc_id),
        .free_count  (free_count),
        .rel_ena     (rel_ena),
        .rel_id      (old_wb)
    );

    // Ascending port order makes the highest-index writer win.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        wid     = '0;
        for (int i = 0; i < WB_PORTS; i++) begin
            wid = wb_id[i*ID_W +: ID_W];
            if (wb_ena[i] && wid != '0) begin
                data_d[wid]  = wb_val[i*DATA_W +: DATA_W];
                ready_d[wid] = 1'b1;
            end
        end
        if (alloc_grant) ready_d[alloc_id] = 1'b0;
    end

    always_comb begin
        tx_d   = '0;
        cid_d  = cid_q;
        cval_d = cval_q;
        rid    = '0;
        hit    = 1'b0;
        bval   = '0;
        for (int j = 0; j < RD_PORTS; j++) begin
            rid  = requested_id[j*ID_W +: ID_W];
            hit  = 1'b0;
            bval = '0;
            for (int i = 0; i < WB_PORTS; i++) begin
                if (wb_ena[i] && wb_id[i*ID_W +: ID_W] == rid && rid != '0) begin
                    hit  = 1'b1;
                    bval = wb_val[i*DATA_W +: DATA_W];
                end
            end
            if (requesting[j] && (hit || ready_q[rid])) begin
                tx_d[j]                    = 1'b1;
                cid_d[j*ID_W +: ID_W]      = rid;
                cval_d[j*DATA_W +: DATA_W] = hit ? bval : data_q[rid];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                data_q[i]  <= '0;
                ready_q[i] <= (i < ARCH_REGS) || (i == 0);
            end
            tx_q   <= '0;
            cid_q  <= '0;
            cval_q <= '0;
        end else begin
            data_q  <= data_d;
            ready_q <= ready_d;
            tx_q    <= tx_d;
            cid_q   <= cid_d;
            cval_q  <= cval_d;
        end
    end

    assign ready_regs   = ready_q;
    assign cdb_transmit = tx_q;
    assign cdb_id       = cid_q;
    assign cdb_val      = cval_q;

endmodule

// File: tb/tb_prf_multiport.sv
// Directed plus randomized checks of prf_multiport against an array-based model.
module tb_prf_multiport;

    localparam int PRF_SIZE  = 16;
    localparam int DATA_W    = 8;
    localparam int ARCH_REGS = 8;
    localparam int WB_PORTS  = 2;
    localparam int RD_PORTS  = 2;
    localparam int ID_W      = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [WB_PORTS-1:0]        wb_ena;
    logic [WB_PORTS*ID_W-1:0]   wb_id;
    logic [WB_PORTS*DATA_W-1:0] wb_val;
    logic                       alloc_req;
    logic                       alloc_grant;
    logic [ID_W-1:0]            alloc_id;
    logic [ID_W:0]              free_count;
    logic                       rel_ena;
    logic [ID_W-1:0]            old_wb;
    logic [RD_PORTS-1:0]        requesting;
    logic [RD_PORTS*ID_W-1:0]   requested_id;
    logic [PRF_SIZE-1:0]        ready_regs;
    logic [RD_PORTS-1:0]        cdb_transmit;
    logic [RD_PORTS*ID_W-1:0]   cdb_id;
    logic [RD_PORTS*DATA_W-1:0] cdb_val;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_data  [PRF_SIZE];
    bit m_ready [PRF_SIZE];
    bit m_free  [PRF_SIZE];
    bit m_tx    [RD_PORTS];
    int m_cid   [RD_PORTS];
    int m_cval  [RD_PORTS];

    always #5 clk = ~clk;

    prf_multiport #(
        .PRF_SIZE  (PRF_SIZE),
        .DATA_W    (DATA_W),
        .ARCH_REGS (ARCH_REGS),
        .WB_PORTS  (WB_PORTS),
        .RD_PORTS  (RD_PORTS),
        .ID_W      (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_ena       (wb_ena),
        .wb_id        (wb_id),
        .wb_val       (wb_val),
        .alloc_req    (alloc_req),
        .alloc_grant  (alloc_grant),
        .alloc_id     (alloc_id),
        .free_count   (free_count),
        .rel_ena      (rel_ena),
        .old_wb       (old_wb),
        .requesting   (requesting),
        .requested_id (requested_id),
        .ready_regs   (ready_regs),
        .cdb_transmit (cdb_transmit),
        .cdb_id       (cdb_id),
        .cdb_val      (cdb_val)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < PRF_SIZE; i++) begin
            m_data[i]  = 0;
            m_ready[i] = (i < ARCH_REGS);
            m_free[i]  = (i >= ARCH_REGS);
        end
        for (int j = 0; j < RD_PORTS; j++) begin
            m_tx[j] = 0; m_cid[j] = 0; m_cval[j] = 0;
        end
    endtask

    function automatic int model_lowest();
        for (int i = 1; i < PRF_SIZE; i++) if (m_free[i]) return i;
        return -1;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < PRF_SIZE; i++) c += int'(m_free[i]);
        return c;
    endfunction

    task automatic idle();
        wb_ena = '0; wb_id = '0; wb_val = '0;
        alloc_req = 0; rel_ena = 0; old_wb = '0;
        requesting = '0; requested_id = '0;
    endtask

    task automatic check_regs();
        logic [PRF_SIZE-1:0]        er;
        logic [RD_PORTS-1:0]        et;
        logic [RD_PORTS*ID_W-1:0]   ei;
        logic [RD_PORTS*DATA_W-1:0] ev;
        for (int i = 0; i < PRF_SIZE; i++) er[i] = m_ready[i];
        for (int j = 0; j < RD_PORTS; j++) begin
            et[j] = m_tx[j];
            ei[j*ID_W +: ID_W] = ID_W'(m_cid[j]);
            ev[j*DATA_W +: DATA_W] = DATA_W'(m_cval[j]);
        end
        check_eq("free_count", free_count, model_count());
        check_eq("ready_regs", ready_regs, er);
        check_eq("cdb_transmit", cdb_transmit, et);
        check_eq("cdb_id", cdb_id, ei);
        check_eq("cdb_val", cdb_val, ev);
    endtask

    // Call with inputs driven shortly after a rising edge; returns 1 unit after the next edge.
    task automatic cycle();
        int  low, aid, rid, hv, wid;
        bit  grant, hit, rel_ok;
        #2;
        low   = model_lowest();
        grant = alloc_req && (low >= 0);
        aid   = (low >= 0) ? low : 0;
        check_eq("alloc_grant", alloc_grant, grant);
        check_eq("alloc_id", alloc_id, aid);
        @(posedge clk);
        for (int j = 0; j < RD_PORTS; j++) begin
            m_tx[j] = 0;
            rid = int'(requested_id[j*ID_W +: ID_W]);
            hit = 0; hv = 0;
            for (int i = 0; i < WB_PORTS; i++) begin
                if (wb_ena[i] && int'(wb_id[i*ID_W +: ID_W]) == rid && rid != 0) begin
                    hit = 1; hv = int'(wb_val[i*DATA_W +: DATA_W]);
                end
            end
            if (requesting[j] && (hit || m_ready[rid])) begin
                m_tx[j] = 1; m_cid[j] = rid; m_cval[j] = hit ? hv : m_data[rid];
            end
        end
        rel_ok = rel_ena && old_wb != 0 && !m_free[old_wb];
        for (int i = 0; i < WB_PORTS; i++) begin
            wid = int'(wb_id[i*ID_W +: ID_W]);
            if (wb_ena[i] && wid != 0) begin
                m_data[wid] = int'(wb_val[i*DATA_W +: DATA_W]); m_ready[wid] = 1;
            end
        end
        if (grant) begin m_free[aid] = 0; m_ready[aid] = 0; end
        if (rel_ok) m_free[old_wb] = 1;
        #1;
        check_regs();
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        #13;
        check_eq("rst_ready", ready_regs, 16'h00FF);
        check_eq("rst_free_count", free_count, 8);
        check_eq("rst_cdb_transmit", cdb_transmit, 0);
        check_eq("rst_cdb_val", cdb_val, 0);
        rst = 0;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) begin
            alloc_req = 1;
            #1 check_eq("alloc_seq_id", alloc_id, 8 + k);
            cycle();
            check_eq("alloc_seq_count", free_count, 7 - k);
        end
        alloc_req = 1;
        #1 check_eq("alloc_empty_grant", alloc_grant, 0);
        cycle();

        idle(); wb_ena = 2'b01; wb_id[3:0] = 4'd9; wb_val[7:0] = 8'hA5;
        cycle();
        idle(); requesting = 2'b10; requested_id[7:4] = 4'd9;
        cycle();
        check_eq("rd9_tx", cdb_transmit[1], 1);
        check_eq("rd9_id", cdb_id[7:4], 9);
        check_eq("rd9_val", cdb_val[15:8], 8'hA5);
        check_eq("rd9_ready", ready_regs[9], 1);

        idle(); wb_ena = 2'b11; wb_id = {4'd10, 4'd10}; wb_val = {8'hC7, 8'hB6};
        requesting = 2'b01; requested_id[3:0] = 4'd10;
        cycle();
        check_eq("bypass_tx", cdb_transmit[0], 1);
        check_eq("bypass_val", cdb_val[7:0], 8'hC7);

        idle(); requesting = 2'b01; requested_id[3:0] = 4'd11;
        cycle();
        check_eq("unready_tx", cdb_transmit[0], 0);

        idle(); rel_ena = 1; old_wb = 4'd3; alloc_req = 1;
        #1 check_eq("rel_same_cycle_grant", alloc_grant, 0);
        cycle();
        check_eq("rel_count", free_count, 1);
        idle();
        #1 check_eq("rel_visible_id", alloc_id, 3);
        cycle();
        alloc_req = 1;
        cycle();
        check_eq("realloc_count", free_count, 0);
        idle(); rel_ena = 1; old_wb = 4'd3;
        cycle();
        cycle();
        check_eq("double_rel_count", free_count, 1);
        old_wb = 4'd0;
        cycle();
        check_eq("rel_zero_count", free_count, 1);

        idle(); requesting = 2'b01; requested_id[3:0] = 4'd9;
        cycle();
        idle();
        rst = 1;
        #1;
        check_eq("midrst_tx", cdb_transmit, 0);
        check_eq("midrst_ready", ready_regs, 16'h00FF);
        check_eq("midrst_count", free_count, 8);
        model_reset();
        #2 rst = 0;
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            wb_ena       = WB_PORTS'($urandom);
            wb_id        = (WB_PORTS*ID_W)'($urandom);
            wb_val       = (WB_PORTS*DATA_W)'($urandom);
            alloc_req    = ($urandom_range(0, 2) == 0);
            rel_ena      = ($urandom_range(0, 2) == 0);
            old_wb       = ID_W'($urandom);
            requesting   = RD_PORTS'($urandom);
            requested_id = (RD_PORTS*ID_W)'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prf_multiport.md
# prf_multiport

Parametrised physical register file for the out-of-order core: multiple writeback ports, multiple CDB read/broadcast ports, an integrated free list for rename allocation, and retire-time release of old mappings. It sits between rename (allocation), the execution units (writeback) and the reservation stations (ready bits and CDB reads). It replaces the single-port `prf`.

## Interface
- `PRF_SIZE`, 16: number of physical registers; power of two, at least 4.
- `DATA_W`, 8: register data width.
- `ARCH_REGS`, 8: physical regs 0..ARCH_REGS-1 hold the initial architectural mapping at reset; must be less than PRF_SIZE.
- `WB_PORTS`, 2: number of writeback ports.
- `RD_PORTS`, 2: number of read/CDB ports.
- `ID_W`, $clog2(PRF_SIZE): physical id width (derived).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wb_ena`  in  WB_PORTS  per-port write enable.
- `wb_id`  in  WB_PORTS*ID_W  per-port destination id; port i occupies bits [i*ID_W +: ID_W].
- `wb_val`  in  WB_PORTS*DATA_W  per-port write data.
- `alloc_req`  in  1  rename requests one free register.
- `alloc_grant`  out  1  combinational; high when alloc_req is high and the free list is non-empty.
- `alloc_id`  out  ID_W  combinational; lowest-index free register, or 0 when the list is empty.
- `free_count`  out  ID_W+1  registered count of free registers.
- `rel_ena`  in  1  retire releases a register.
- `old_wb`  in  ID_W  id being released.
- `requesting`  in  RD_PORTS  per-port read request.
- `requested_id`  in  RD_PORTS*ID_W  per-port read id.
- `ready_regs`  out  PRF_SIZE  registered per-register ready bits.
- `cdb_transmit`  out  RD_PORTS  registered; read result valid.
- `cdb_id`  out  RD_PORTS*ID_W  registered id of the value.
- `cdb_val`  out  RD_PORTS*DATA_W  registered value.

## Operation
- **Reset (async, immediate):**
  - All data is cleared to 0.
  - Regs 0..ARCH_REGS-1 are allocated and ready; the remaining registers are free and not ready.
  - free_count = PRF_SIZE-ARCH_REGS.
  - cdb_transmit, cdb_id and cdb_val are all 0.
- **Reg 0 is the zero register:**
  - It is always ready and always reads 0.
  - Writes to it are ignored, and a release of it is ignored.
  - It is never allocatable.
- **Allocation:**
  - On alloc_grant, at the clock edge, alloc_id is marked allocated and its ready bit is cleared.
  - When the free list is empty, alloc_grant=0 and nothing changes.
- **Release:**
  - When rel_ena is high and old_wb is non-zero, old_wb is marked free at the edge. Its ready bit and data are left unchanged.
  - Releasing a register that is already free is a no-op; free_count must not double-count.
- **Writeback:** for each wb_ena[i], the data is written and the ready bit is set.
  - When two ports target the same id, the higher port index wins.
- **Read:**
  - For each requesting[j], sample requested_id[j].
  - When the target is ready, or is being written this cycle (write-first bypass, highest port wins), the next cycle has cdb_transmit[j]=1, cdb_id[j] equal to the id, and cdb_val[j] equal to the value.
  - When the target is not ready, cdb_transmit[j]=0; the requester retries.
  - When requesting[j]=0, cdb_transmit[j]=0 next cycle; cdb_id and cdb_val hold their previous values.
- **Simultaneous events:**
  - A register released in cycle N is not visible to alloc_id until cycle N+1.
  - free_count(next) = free_count + released − granted, evaluated at the same edge.
  - Allocation and writeback to the same id in one cycle: the data is written, and the ready bit ends cleared (allocation wins).

## Timing
- Allocation: alloc_id and alloc_grant are valid in the same cycle as alloc_req; state updates at the edge.
- Read latency is 1 cycle: request at edge N, result visible after edge N+1.
- ready_regs reflects writebacks one cycle after wb_ena.
- There is no backpressure: every port is serviced every cycle.
- Asserting rst mid-operation:
  - Aborts all in-flight reads.
  - cdb_transmit drops immediately.

## Structure
- A shared package `prf_pkg` holds:
  - default parameter constants;
  - the function `lowest_set(vec)` returning the index and a found flag.
- A sub-module `prf_free_list` holds the free bitmap, priority encoder, free_count, alloc and release logic, and reset mapping.
- The top level holds the data array, ready bits, writeback merge and read pipeline.

## Test plan
- Reset, then allocate 8 times in a row → alloc_id sequence 8..15; free_count goes 8→0; the 9th alloc_req gives alloc_grant=0.
- Write wb_id=9 with A5 on port 0, then read id 9 on port 1 → one cycle later cdb_transmit[1]=1, cdb_id=9, cdb_val=A5; ready_regs[9]=1.
- Port 0 writes id 10 = B6 and port 1 writes id 10 = C7 in the same cycle, with a read of id 10 in that same cycle → cdb_val=C7 (bypass, higher port wins).
- Read a freshly allocated, unwritten id 11 → cdb_transmit=0.
- Release old_wb=3 while the free list is empty and alloc_req is asserted in the same cycle → alloc_grant=0 that cycle; next cycle alloc_id=3 and free_count=1.
  - A repeated release of 3 after re-allocation is counted once; releases of id 0 are ignored.
- Assert rst while a read is pending → cdb_transmit=0 immediately; the state returns to the reset mapping.
